register_bank: RTL
==================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, the width of each register and of each data port in bits.
REQ-002 SHALL provide parameter NUM_REGS, default 32, the register count and the width of wr_sel.
REQ-003 SHALL provide parameter ZERO_REG0, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 wr_en  input  1  write strobe qualifying wr_sel and wr_data.
REQ-007 wr_sel  input  NUM_REGS  one-hot write select from the upstream address decoder; bit i selects register i.
REQ-008 wr_data  input  DATA_WIDTH  write data.
REQ-009 rd_addr1  input  5  read port 1 register index, binary.
REQ-010 rd_addr2  input  5  read port 2 register index, binary.
REQ-011 rd_data1  output  DATA_WIDTH  registered read data, port 1.
REQ-012 rd_data2  output  DATA_WIDTH  registered read data, port 2.
REQ-013 sel_err  output  1  sticky flag; set by a malformed write select.
REQ-014 wr_count  output  16  count of committed writes.

Function
REQ-015 A write SHALL commit at the rising edge of clk when wr_en=1 and wr_sel has exactly one bit set: register i takes wr_data, where i is the set bit.
REQ-016 When wr_en=1 and wr_sel is all-zero or has two or more bits set, no register SHALL change, and sel_err SHALL be 1 from the next cycle until reset.
REQ-017 When wr_en=0, wr_sel SHALL be ignored: no write and no sel_err update.
REQ-018 With ZERO_REG0=1, a valid select of bit 0 SHALL neither change register 0 nor set sel_err, and SHALL still increment wr_count.
REQ-019 rd_dataN SHALL show the contents of register rd_addrN, sampled at edge k, from edge k onward (1-cycle latency).
REQ-020 Read-during-write SHALL be write-first: if a write commits at edge k to the register addressed by rd_addrN at that edge, rd_dataN after edge k SHALL equal wr_data.
REQ-021 A read of register 0 SHALL return zero when ZERO_REG0=1, including under the bypass of REQ-020.
REQ-022 Both read ports SHALL operate independently, with identical timing, and MAY address the same register.
REQ-023 An rd_addrN value at or above NUM_REGS SHALL return zero on rd_dataN.
REQ-024 wr_count SHALL increment by 1 on each committed write per REQ-015 and REQ-018, wrap from 0xFFFF to 0x0000, and never count rejected writes.

Reset
REQ-025 When rst=1 at a rising edge, all registers, rd_data1, rd_data2, sel_err and wr_count SHALL be 0 after that edge.
REQ-026 Reset SHALL take priority over a simultaneous write: no write commits and wr_count stays 0.
REQ-027 Outputs SHALL not change between clock edges, reset included.

Verification
REQ-028 The bench SHALL cover these directed scenarios.
- Reset, then read all 32 addresses -> every rd_data is 0; sel_err=0; wr_count=0.
- Write 0xDEADBEEF with wr_sel=32'h0000_0020; read rd_addr1=5 next cycle -> rd_data1=0xDEADBEEF; wr_count=1.
- Same edge: write 0x12345678 to register 7 with rd_addr1=7 and rd_addr2=7 -> both ports show 0x12345678 after that edge.
- Write 0xFFFFFFFF with wr_sel=32'h0000_0001 (ZERO_REG0=1); read address 0 -> 0; wr_count increments; sel_err=0.
- wr_en=1 with wr_sel=32'h0000_0003, then with 32'h0 -> registers 0 and 1 unchanged; sel_err=1 and held; wr_count unchanged; rst -> sel_err=0.
- Preload wr_count to 0xFFFF with 65535 writes, then write once more -> wr_count=0x0000; then assert rst together with a write to register 3 -> register 3 reads 0.

Source files
------------

// File: rtl/register_bank.sv
// Register file with a one-hot write port, two registered write-first read ports,
// a sticky malformed-select flag and a wrapping count of committed writes.
module register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG0  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [NUM_REGS-1:0]   wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]            rd_addr1,
  input  logic [4:0]            rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  sel_err,
  output logic [15:0]           wr_count
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_rd_data1;
  logic [DATA_WIDTH-1:0] r_rd_data2;
  logic                  r_sel_err;
  logic [15:0]           r_wr_count;

  logic                  w_onehot;
  logic                  w_commit;
  logic [NUM_REGS-1:0]   w_hit;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign w_onehot = (wr_sel != '0) && ((wr_sel & (wr_sel - NUM_REGS'(1))) == '0);
  assign w_commit = wr_en && w_onehot;

  // Register 0 is excluded from the hit vector when hardwired to zero, which
  // also keeps the read bypass from leaking write data onto address 0.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_hit[i] = w_commit && wr_sel[i] && !((ZERO_REG0 != 0) && (i == 0));
    end
  end

  // Addresses at or above NUM_REGS match no entry and fall through to zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_addr1) == i) w_rd1 = w_hit[i] ? wr_data : r_regs[i];
      if (32'(rd_addr2) == i) w_rd2 = w_hit[i] ? wr_data : r_regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
      r_sel_err  <= 1'b0;
      r_wr_count <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_hit[i]) r_regs[i] <= wr_data;
      end
      r_rd_data1 <= w_rd1;
      r_rd_data2 <= w_rd2;
      if (wr_en && !w_onehot) r_sel_err <= 1'b1;
      if (w_commit) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign sel_err  = r_sel_err;
  assign wr_count = r_wr_count;

endmodule
